// File: rtl/mips_cpu_bus_bridge.sv
// Sequences one Harvard-core instruction at a time over a single Avalon-style bus:
// fetch, decode, optional load/store, then a one-cycle commit pulse to the core.
module mips_cpu_bus_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_active,
  input  logic [ADDR_WIDTH-1:0]   instr_address,
  output logic [DATA_WIDTH-1:0]   instr_readdata,
  input  logic [ADDR_WIDTH-1:0]   data_address,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [DATA_WIDTH/8-1:0] data_byteenable,
  input  logic [DATA_WIDTH-1:0]   data_writedata,
  output logic [DATA_WIDTH-1:0]   data_readdata,
  output logic                    clk_enable,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    read,
  output logic                    write,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  output logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    waitrequest,
  input  logic [DATA_WIDTH-1:0]   readdata,
  output logic                    bus_error,
  output logic [COUNT_WIDTH-1:0]  instr_count
);

  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT - 1);
  localparam logic [BE_WIDTH-1:0]   BE_ALL    = {BE_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic                    read_r, read_s, write_r, write_s;
  logic                    clk_enable_r, clk_enable_s, bus_error_r, bus_error_s;
  logic [ADDR_WIDTH-1:0]   address_r, address_s;
  logic [BE_WIDTH-1:0]     byteenable_r, byteenable_s;
  logic [DATA_WIDTH-1:0]   writedata_r, writedata_s;
  logic [DATA_WIDTH-1:0]   instr_readdata_r, instr_readdata_s;
  logic [DATA_WIDTH-1:0]   data_readdata_r, data_readdata_s;
  logic [COUNT_WIDTH-1:0]  instr_count_r, instr_count_s;
  logic [WAIT_WIDTH-1:0]   wait_cnt_r, wait_cnt_s;
  logic                    xfer_active_s, done_s, timeout_s;

  // A transfer completes or times out only while one of our strobes is up.
  assign xfer_active_s = read_r | write_r;
  assign done_s        = xfer_active_s & ~waitrequest;
  assign timeout_s     = xfer_active_s & waitrequest & (wait_cnt_r == WAIT_LAST);

  // Consecutive stalled cycles of the current transfer.
  always_comb begin
    if (xfer_active_s && waitrequest && !timeout_s) begin
      wait_cnt_s = wait_cnt_r + WAIT_WIDTH'(1);
    end else begin
      wait_cnt_s = {WAIT_WIDTH{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (timeout_s) begin
          state_s = ST_COMMIT;
        end else if (done_s) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (data_read != data_write) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_COMMIT;
        end
      end
      ST_DATA: begin
        if (timeout_s || done_s) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_COMMIT: begin
        if (core_active) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HALT;
        end
      end
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_FETCH;
    endcase
  end

  // Next values of the registered bus, core-facing and status outputs.
  always_comb begin
    read_s           = 1'b0;
    write_s          = 1'b0;
    clk_enable_s     = (state_s == ST_COMMIT);
    bus_error_s      = bus_error_r;
    address_s        = address_r;
    byteenable_s     = byteenable_r;
    writedata_s      = writedata_r;
    instr_readdata_s = instr_readdata_r;
    data_readdata_s  = data_readdata_r;
    instr_count_s    = instr_count_r;
    case (state_r)
      ST_FETCH: begin
        if (timeout_s) begin
          bus_error_s = 1'b1;
        end else if (done_s) begin
          instr_readdata_s = readdata;
        end else begin
          // Out of reset FETCH has no strobe yet; issue it here.
          read_s = 1'b1;
          if (!read_r) begin
            address_s    = instr_address;
            byteenable_s = BE_ALL;
          end else begin
            address_s = address_r;
          end
        end
      end
      ST_DECODE: begin
        if (data_read && data_write) begin
          bus_error_s = 1'b1;
        end else if (data_read) begin
          read_s       = 1'b1;
          address_s    = data_address;
          byteenable_s = data_byteenable;
        end else if (data_write) begin
          write_s      = 1'b1;
          address_s    = data_address;
          byteenable_s = data_byteenable;
          writedata_s  = data_writedata;
        end else begin
          bus_error_s = bus_error_r;
        end
      end
      ST_DATA: begin
        if (timeout_s) begin
          bus_error_s = 1'b1;
        end else if (done_s) begin
          if (read_r) begin
            data_readdata_s = readdata;
          end else begin
            data_readdata_s = data_readdata_r;
          end
        end else begin
          read_s  = read_r;
          write_s = write_r;
        end
      end
      ST_COMMIT: begin
        instr_count_s = instr_count_r + COUNT_WIDTH'(1);
        if (core_active) begin
          read_s       = 1'b1;
          address_s    = instr_address;
          byteenable_s = BE_ALL;
        end else begin
          read_s = 1'b0;
        end
      end
      ST_HALT: begin
        read_s = 1'b0;
      end
      default: begin
        read_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset clears strobes asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_r           <= 1'b0;
      write_r          <= 1'b0;
      clk_enable_r     <= 1'b0;
      bus_error_r      <= 1'b0;
      address_r        <= {ADDR_WIDTH{1'b0}};
      byteenable_r     <= BE_ALL;
      writedata_r      <= {DATA_WIDTH{1'b0}};
      instr_readdata_r <= {DATA_WIDTH{1'b0}};
      data_readdata_r  <= {DATA_WIDTH{1'b0}};
      instr_count_r    <= {COUNT_WIDTH{1'b0}};
      wait_cnt_r       <= {WAIT_WIDTH{1'b0}};
    end else begin
      read_r           <= read_s;
      write_r          <= write_s;
      clk_enable_r     <= clk_enable_s;
      bus_error_r      <= bus_error_s;
      address_r        <= address_s;
      byteenable_r     <= byteenable_s;
      writedata_r      <= writedata_s;
      instr_readdata_r <= instr_readdata_s;
      data_readdata_r  <= data_readdata_s;
      instr_count_r    <= instr_count_s;
      wait_cnt_r       <= wait_cnt_s;
    end
  end

  assign read           = read_r;
  assign write          = write_r;
  assign clk_enable     = clk_enable_r;
  assign bus_error      = bus_error_r;
  assign address        = address_r;
  assign byteenable     = byteenable_r;
  assign writedata      = writedata_r;
  assign instr_readdata = instr_readdata_r;
  assign data_readdata  = data_readdata_r;
  assign instr_count    = instr_count_r;

endmodule

// File: doc/mips_cpu_bus_bridge.md
Name: mips_cpu_bus_bridge

Overview:
Parametrised successor to the single-cycle Harvard core top. It sequences one core instruction at a time over a single shared Avalon-style memory bus with `waitrequest`. It holds the fetched instruction and the loaded data word stable toward the core, and drives the core's `clk_enable` so the core commits exactly one instruction per bus transaction sequence. It sits between the unchanged Harvard-ported core and the bus-based memory, and adds stall handling, a wait-state timeout, byte enables, halt detection and an instruction counter.

Parameters:
- ADDR_WIDTH, 32, width of every address port.
- DATA_WIDTH, 32, width of every data port; must be a multiple of 8.
- TIMEOUT, 255, maximum consecutive cycles `waitrequest` may stay high on one transfer before `bus_error` sets; must be ≥1.
- COUNT_WIDTH, 32, width of `instr_count`.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- core_active  input  1  core running; 0 means the core has halted.
- instr_address  input  ADDR_WIDTH  fetch address from the core PC.
- instr_readdata  output  DATA_WIDTH  registered instruction word to the core.
- data_address  input  ADDR_WIDTH  load/store address from the core.
- data_read  input  1  core requests a load this instruction.
- data_write  input  1  core requests a store this instruction.
- data_byteenable  input  DATA_WIDTH/8  byte lanes of the load/store.
- data_writedata  input  DATA_WIDTH  store data.
- data_readdata  output  DATA_WIDTH  registered load data to the core.
- clk_enable  output  1  one-cycle commit pulse to the core.
- address  output  ADDR_WIDTH  bus address.
- read  output  1  bus read strobe.
- write  output  1  bus write strobe.
- byteenable  output  DATA_WIDTH/8  bus byte lanes.
- writedata  output  DATA_WIDTH  bus write data.
- waitrequest  input  1  bus stall; a transfer completes in the first cycle it is 0 with a strobe high.
- readdata  input  DATA_WIDTH  bus read data; valid in the completing cycle.
- bus_error  output  1  sticky error flag.
- instr_count  output  COUNT_WIDTH  number of committed instructions.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH; `read`, `write`, `clk_enable`, `bus_error` = 0; `instr_readdata`, `data_readdata`, `instr_count`, wait counter = 0; `address`, `writedata` = 0; `byteenable` = all ones. A reset asserted mid-transfer drops the strobes immediately, not at the next edge.
- Strobes, `address`, `byteenable` and `writedata` are registered; each is held constant while `waitrequest`=1.
- FETCH:
  - `read`=1, `address`=`instr_address`, `byteenable`=all ones.
  - On completion: latch `readdata` into `instr_readdata`.
  - Next state is DATA if `data_read` or `data_write` (evaluated the cycle after the latch, once the core has decoded), else COMMIT. The decision needs a one-cycle DECODE state between FETCH and DATA/COMMIT.
- DECODE: no strobes. Sample `data_read`/`data_write`.
  - Both high: set `bus_error`, go to COMMIT with no bus transfer.
  - Read only: go to DATA with `read`=1.
  - Write only: go to DATA with `write`=1, `writedata`=`data_writedata`.
  - Neither: go to COMMIT.
  - In every DATA case, `address`=`data_address` and `byteenable`=`data_byteenable`.
- DATA: hold the strobe until completion. On a read completion, latch `readdata` into `data_readdata`. Then go to COMMIT.
- COMMIT: `clk_enable`=1 for exactly this cycle; `instr_count` increments, wrapping at 2^COUNT_WIDTH. Next state is FETCH if `core_active`=1, else HALT.
- HALT: no strobes, `clk_enable`=0. Absorbing state until reset.
- `clk_enable` is 0 in every state except COMMIT.
- Latency with zero wait states:
  - Non-memory instruction: FETCH, DECODE, COMMIT = 3 cycles.
  - Load/store: 4 cycles.
- Timeout:
  - The wait counter increments each cycle a strobe is high with `waitrequest`=1, and clears on completion.
  - On reaching TIMEOUT: set `bus_error`, drop the strobe, go to COMMIT. Latched data keeps its previous value.
  - `bus_error` is cleared only by reset.
- `waitrequest` high while no strobe is asserted is ignored.

Test Plan:
1. Zero-wait bus, `instr_address`=0xBFC00000, `readdata`=0x24020005 (addiu v0), no data request → `read` high 1 cycle at 0xBFC00000; `clk_enable` pulses on cycle 3; `instr_count`=1.
2. Load with `waitrequest` high for 4 cycles, `data_address`=0x1000, `readdata`=0xDEADBEEF → `read`/`address` held stable for 5 cycles; `data_readdata`=0xDEADBEEF; exactly one `clk_enable` pulse.
3. Store with `data_byteenable`=4'b0011, `data_writedata`=0x0000ABCD → one write cycle with `byteenable`=0011 and `writedata`=0x0000ABCD; `read`=0 throughout.
4. TIMEOUT=4, `waitrequest` held high → `bus_error`=1 after the 4th wait cycle; strobe drops; commit follows; the flag stays 1 over the next 10 instructions.
5. `core_active`=0 at the commit → HALT; no strobes and no `clk_enable` for 20 cycles; `instr_count` frozen.
6. Assert reset mid-DATA with `write`=1 → `write`=0 in the same cycle, before the next clock edge; after release the first access is a FETCH read and `instr_count`=0.
